// File: rtl/hazard_scoreboard.sv
// RAW hazard detector for a forwarding-less pipeline: remembers in-flight
// destination registers and stalls decode while a source register is still pending.
module hazard_scoreboard #(
    parameter int DEPTH     = 3,
    parameter int RF_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       Rs,
    input  logic             Rs_valid,
    input  logic [2:0]       Rt,
    input  logic             Rt_valid,
    input  logic [2:0]       Rd,
    input  logic             Rd_valid,
    input  logic             id_reg_write,
    input  logic             flush,
    output logic             stall,
    output logic             bubble,
    output logic [7:0]       pending_mask,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] stall_events
);

    // With the bypass on, the oldest entry writes the RF in time for this read.
    localparam int WIN = DEPTH - RF_BYPASS;

    logic [DEPTH-1:0]      v_q, v_d;
    logic [DEPTH-1:0][2:0] r_q, r_d;
    logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]      stall_events_q, stall_events_d;
    logic                  stall_q;

    logic match_rs, match_rt, hazard;
    logic ins_v, ins_keep;

    always_comb begin
        match_rs = 1'b0;
        match_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < WIN) begin
                if (v_q[i] && (r_q[i] == Rs)) match_rs = 1'b1;
                if (v_q[i] && (r_q[i] == Rt)) match_rt = 1'b1;
            end
        end
    end

    assign hazard = id_valid & ((Rs_valid & match_rs) | (Rt_valid & match_rt));
    assign stall  = hazard & ~flush;
    assign bubble = stall | flush;

    // A held or killed instruction enters the queue as an empty slot.
    assign ins_keep = id_valid & ~stall & ~flush;
    assign ins_v    = ins_keep & Rd_valid & id_reg_write;

    always_comb begin
        v_d    = '0;
        r_d    = '0;
        v_d[0] = ins_v;
        r_d[0] = ins_keep ? Rd : 3'd0;
        for (int i = 1; i < DEPTH; i++) begin
            v_d[i] = v_q[i-1];
            r_d[i] = r_q[i-1];
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (v_q[i]) pending_mask[r_q[i]] = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        stall_events_d = stall_events_q;
        if (stall && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (stall && !stall_q && (stall_events_q != '1))
            stall_events_d = stall_events_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q            <= '0;
            r_q            <= '0;
            stall_cycles_q <= '0;
            stall_events_q <= '0;
            stall_q        <= 1'b0;
        end else begin
            v_q            <= v_d;
            r_q            <= r_d;
            stall_cycles_q <= stall_cycles_d;
            stall_events_q <= stall_events_d;
            stall_q        <= stall;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign stall_events = stall_events_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance plus a no-bypass
// instance with 2-bit counters sharing the same decode inputs.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic       id_valid, Rs_valid, Rt_valid, Rd_valid, id_reg_write, flush;
    logic [2:0] Rs, Rt, Rd;

    logic        stall_a, bubble_a, stall_b, bubble_b;
    logic [7:0]  pm_a, pm_b;
    logic [15:0] sc_a, se_a;
    logic [1:0]  sc_b, se_b;

    int checks = 0;
    int fails  = 0;

    hazard_scoreboard dut_a (
        .clk(clk), .rst(rst_a), .id_valid(id_valid),
        .Rs(Rs), .Rs_valid(Rs_valid), .Rt(Rt), .Rt_valid(Rt_valid),
        .Rd(Rd), .Rd_valid(Rd_valid), .id_reg_write(id_reg_write), .flush(flush),
        .stall(stall_a), .bubble(bubble_a), .pending_mask(pm_a),
        .stall_cycles(sc_a), .stall_events(se_a)
    );

    hazard_scoreboard #(.DEPTH(3), .RF_BYPASS(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst_b), .id_valid(id_valid),
        .Rs(Rs), .Rs_valid(Rs_valid), .Rt(Rt), .Rt_valid(Rt_valid),
        .Rd(Rd), .Rd_valid(Rd_valid), .id_reg_write(id_reg_write), .flush(flush),
        .stall(stall_b), .bubble(bubble_b), .pending_mask(pm_b),
        .stall_cycles(sc_b), .stall_events(se_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] rs, input logic rsv,
                         input logic [2:0] rt, input logic rtv, input logic [2:0] rd,
                         input logic rdv, input logic wr, input logic fl);
        id_valid = v;  Rs = rs; Rs_valid = rsv; Rt = rt; Rt_valid = rtv;
        Rd = rd; Rd_valid = rdv; id_reg_write = wr; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 3'bx, 1'bx, 3'bx, 1'bx, 3'bx, 1'bx, 1'bx, 1'b0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle();
        flush = 1'b1;
        next();
        check("rst_stall_a",  stall_a,  1'b0);
        check("rst_bubble_a", bubble_a, 1'b1);
        check("rst_pm_a",     pm_a,     8'h00);
        check("rst_sc_a",     sc_a,     16'd0);
        check("rst_se_a",     se_a,     16'd0);
        check("rst_stall_b",  stall_b,  1'b0);
        check("rst_bubble_b", bubble_b, 1'b1);
        check("rst_pm_b",     pm_b,     8'h00);
        flush = 1'b0;
        rst_a = 1'b1;
        next();

        // Dependent ALU pair: two stall cycles at defaults
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
        @(negedge clk); check("t1_writer_stall", stall_a, 1'b0);
        next();
        drive(1, 1, 1, 0, 0, 2, 1, 1, 0);
        @(negedge clk); check("t1_stall_c1", stall_a, 1'b1);
        check("t1_bubble_c1", bubble_a, 1'b1);
        next();
        @(negedge clk); check("t1_stall_c2", stall_a, 1'b1);
        next();
        @(negedge clk); check("t1_stall_c3", stall_a, 1'b0);
        check("t1_sc", sc_a, 16'd2);
        check("t1_se", se_a, 16'd1);
        check("t1_pm", pm_a, 8'h02);
        next();
        // Invalid decode slot reading a pending register must not stall or record
        drive(0, 2, 1, 2, 1, 5, 1, 1, 0);
        @(negedge clk); check("xprop_stall", stall_a, 1'b0);
        check("xprop_pm", pm_a, 8'h04);
        next();
        idle();
        repeat (3) next();
        check("drain_pm", pm_a, 8'h00);

        // Independent sequence
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
        next();
        drive(1, 2, 1, 3, 1, 0, 0, 0, 0);
        @(negedge clk); check("t2_stall", stall_a, 1'b0);
        check("t2_pm_c1", pm_a, 8'h02);
        next();
        idle();
        @(negedge clk); check("t2_pm_c2", pm_a, 8'h02);
        next();
        @(negedge clk); check("t2_pm_c3", pm_a, 8'h02);
        next();
        @(negedge clk); check("t2_pm_c4", pm_a, 8'h00);
        next();

        // Store names Rd but does not write it
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        next();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("t3_stall", stall_a, 1'b0);
        check("t3_pm", pm_a, 8'h00);
        next();

        // Hazard coinciding with flush
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
        next();
        drive(1, 2, 1, 0, 0, 6, 1, 1, 1);
        @(negedge clk); check("t4_stall", stall_a, 1'b0);
        check("t4_bubble", bubble_a, 1'b1);
        next();
        drive(1, 6, 1, 6, 1, 0, 0, 0, 0);
        @(negedge clk); check("t4_next_stall", stall_a, 1'b0);
        check("t4_next_bubble", bubble_a, 1'b0);
        check("t4_pm", pm_a, 8'h04);
        check("t4_sc", sc_a, 16'd2);
        check("t4_se", se_a, 16'd1);
        next();
        idle();
        repeat (3) next();

        // No bypass: r7 reader waits three cycles; 2-bit counters saturate
        rst_b = 1'b1;
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        next();
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("t5_stall_c1", stall_b, 1'b1);
        next();
        @(negedge clk); check("t5_stall_c2", stall_b, 1'b1);
        next();
        @(negedge clk); check("t5_stall_c3", stall_b, 1'b1);
        next();
        @(negedge clk); check("t5_stall_c4", stall_b, 1'b0);
        check("t5_sc", sc_b, 2'd3);
        check("t5_se", se_b, 2'd1);
        next();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
            next();
            drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
            repeat (3) begin
                @(negedge clk); check("t5_loop_stall", stall_b, 1'b1);
                next();
            end
            @(negedge clk); check("t5_loop_release", stall_b, 1'b0);
            next();
        end
        check("t5_se_sat", se_b, 2'd3);
        check("t5_sc_sat", sc_b, 2'd3);
        idle();
        repeat (3) next();

        // Asynchronous reset in the middle of a stall
        drive(1, 0, 0, 0, 0, 4, 1, 1, 0);
        next();
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("t6_pre_stall", stall_a, 1'b1);
        #1 rst_a = 1'b0;
        #1;
        check("t6_rst_stall",  stall_a,  1'b0);
        check("t6_rst_bubble", bubble_a, 1'b0);
        check("t6_rst_pm",     pm_a,     8'h00);
        check("t6_rst_sc",     sc_a,     16'd0);
        check("t6_rst_se",     se_a,     16'd0);
        @(posedge clk);
        #1 rst_a = 1'b1;
        @(negedge clk); check("t6_release_stall", stall_a, 1'b0);
        next();
        idle();
        @(negedge clk); check("t6_release_sc", sc_a, 16'd0);
        check("t6_release_pm", pm_a, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
